// File: rtl/cpu_pkg.sv
// Shared encodings for the hardwired control sequencer: states, opcodes,
// FunSel codes, ALU codes, mux selects and the control bundle.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_CLR  = 3'd0,
    S_F0   = 3'd1,
    S_F1   = 3'd2,
    S_EX   = 3'd3,
    S_MEM  = 3'd4,
    S_HALT = 3'd5
  } state_e;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_OR  = 4'h1;
  localparam logic [3:0] OP_XOR = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_NOT = 4'h5;
  localparam logic [3:0] OP_LSL = 4'h6;
  localparam logic [3:0] OP_LSR = 4'h7;
  localparam logic [3:0] OP_INC = 4'h8;
  localparam logic [3:0] OP_DEC = 4'h9;
  localparam logic [3:0] OP_LDI = 4'hA;
  localparam logic [3:0] OP_LD  = 4'hB;
  localparam logic [3:0] OP_ST  = 4'hC;
  localparam logic [3:0] OP_BRA = 4'hD;
  localparam logic [3:0] OP_BNE = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Register-file / ARF function codes
  localparam logic [1:0] FS_DEC  = 2'b00;
  localparam logic [1:0] FS_INC  = 2'b01;
  localparam logic [1:0] FS_LOAD = 2'b10;
  localparam logic [1:0] FS_CLR  = 2'b11;

  // ALU operation codes
  localparam logic [3:0] ALU_PASSA = 4'b0000;
  localparam logic [3:0] ALU_NOT   = 4'b0010;
  localparam logic [3:0] ALU_ADD   = 4'b0100;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_AND   = 4'b0111;
  localparam logic [3:0] ALU_OR    = 4'b1000;
  localparam logic [3:0] ALU_XOR   = 4'b1001;
  localparam logic [3:0] ALU_LSL   = 4'b1010;
  localparam logic [3:0] ALU_LSR   = 4'b1011;

  // MuxA / MuxB source selects
  localparam logic [1:0] MUX_ALU  = 2'b00;
  localparam logic [1:0] MUX_MEM  = 2'b01;
  localparam logic [1:0] MUX_IMM  = 2'b10;
  localparam logic [1:0] MUX_OUTC = 2'b11;

  // ARF port selects and active-low enables (bit 3 has no register)
  localparam logic [1:0] ARF_PC = 2'b01;
  localparam logic [1:0] ARF_AR = 2'b10;
  localparam logic [1:0] ARF_SP = 2'b11;
  localparam logic [3:0] ARF_EN_PC  = 4'b1110;
  localparam logic [3:0] ARF_EN_AR  = 4'b1101;
  localparam logic [3:0] ARF_EN_ALL = 4'b1000;
  localparam logic [3:0] EN_NONE    = 4'b1111;

  typedef struct packed {
    logic [1:0] rf_outa_sel;
    logic [1:0] rf_outb_sel;
    logic [1:0] rf_funsel;
    logic [3:0] rf_regsel;
    logic [1:0] arf_outc_sel;
    logic [1:0] arf_outd_sel;
    logic [1:0] arf_funsel;
    logic [3:0] arf_regsel;
    logic       ir_lh;
    logic       ir_en;
    logic [1:0] ir_funsel;
    logic [3:0] alu_funsel;
    logic [1:0] mux_a_sel;
    logic [1:0] mux_b_sel;
    logic       mux_c_sel;
    logic       mem_wr;
    logic       mem_cs;
    logic       halted;
  } ctrl_t;

  // Nothing enabled, memory deselected, all selects zero
  localparam ctrl_t CTRL_IDLE = '{
    rf_outa_sel: 2'b00, rf_outb_sel: 2'b00, rf_funsel: 2'b00, rf_regsel: EN_NONE,
    arf_outc_sel: 2'b00, arf_outd_sel: 2'b00, arf_funsel: 2'b00, arf_regsel: EN_NONE,
    ir_lh: 1'b0, ir_en: 1'b0, ir_funsel: 2'b00, alu_funsel: 4'b0000,
    mux_a_sel: 2'b00, mux_b_sel: 2'b00, mux_c_sel: 1'b0,
    mem_wr: 1'b0, mem_cs: 1'b1, halted: 1'b0
  };

  // Active-low enable for a single RegFile register; field value n -> bit n
  function automatic logic [3:0] rf_enable(input logic [1:0] rd);
    rf_enable = ~(4'b0001 << rd);
  endfunction

  // ALU code for the register-register opcodes 0..7
  function automatic logic [3:0] alu_code(input logic [3:0] op);
    case (op)
      OP_AND:  alu_code = ALU_AND;
      OP_OR:   alu_code = ALU_OR;
      OP_XOR:  alu_code = ALU_XOR;
      OP_ADD:  alu_code = ALU_ADD;
      OP_SUB:  alu_code = ALU_SUB;
      OP_NOT:  alu_code = ALU_NOT;
      OP_LSL:  alu_code = ALU_LSL;
      default: alu_code = ALU_LSR;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational decode: current state, opcode fields and zreg -> control bundle.
module ctrl_decode
  import cpu_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  state_e      state,
  input  logic [3:0]  op,
  input  logic [1:0]  rd,
  input  logic [1:0]  rs1,
  input  logic [1:0]  rs2,
  input  logic        zreg,
  output ctrl_t       ctrl
);

  // Drive the datapath for the current state; idle bundle is the default
  always_comb begin
    ctrl = CTRL_IDLE;
    case (state)
      S_CLR: begin
        ctrl.rf_regsel  = 4'b0000;
        ctrl.rf_funsel  = FS_CLR;
        // A zero reset PC is a plain clear of PC/AR/SP; otherwise the ARF loads
        // from IR[7:0] through MuxB, which the datapath must present as RESET_PC.
        ctrl.arf_regsel = ARF_EN_ALL;
        ctrl.arf_funsel = (RESET_PC == 8'h00) ? FS_CLR : FS_LOAD;
        ctrl.mux_b_sel  = MUX_IMM;
      end
      S_F0, S_F1: begin
        ctrl.arf_outd_sel = ARF_PC;
        ctrl.mem_cs       = 1'b0;
        ctrl.ir_en        = 1'b1;
        ctrl.ir_funsel    = FS_LOAD;
        ctrl.ir_lh        = (state == S_F1);
        ctrl.arf_regsel   = ARF_EN_PC;
        ctrl.arf_funsel   = FS_INC;
      end
      S_EX: begin
        if (op[3] == 1'b0) begin
          ctrl.rf_outa_sel = rs1;
          ctrl.rf_outb_sel = rs2;
          ctrl.mux_c_sel   = 1'b0;
          ctrl.mux_a_sel   = MUX_ALU;
          ctrl.alu_funsel  = alu_code(op);
          ctrl.rf_regsel   = rf_enable(rd);
          ctrl.rf_funsel   = FS_LOAD;
        end else begin
          case (op)
            OP_INC, OP_DEC: begin
              ctrl.rf_regsel = rf_enable(rd);
              ctrl.rf_funsel = (op == OP_INC) ? FS_INC : FS_DEC;
            end
            OP_LDI: begin
              ctrl.rf_regsel = rf_enable(rd);
              ctrl.rf_funsel = FS_LOAD;
              ctrl.mux_a_sel = MUX_IMM;
            end
            OP_LD, OP_ST: begin
              ctrl.arf_regsel = ARF_EN_AR;
              ctrl.arf_funsel = FS_LOAD;
              ctrl.mux_b_sel  = MUX_IMM;
            end
            OP_BRA, OP_BNE: begin
              if (op == OP_BRA || !zreg) begin
                ctrl.arf_regsel = ARF_EN_PC;
                ctrl.arf_funsel = FS_LOAD;
                ctrl.mux_b_sel  = MUX_IMM;
              end
            end
            default: ;  // HLT drives nothing
          endcase
        end
      end
      S_MEM: begin
        ctrl.arf_outd_sel = ARF_AR;
        ctrl.mem_cs       = 1'b0;
        if (op == OP_LD) begin
          ctrl.rf_regsel = rf_enable(rd);
          ctrl.rf_funsel = FS_LOAD;
          ctrl.mux_a_sel = MUX_MEM;
        end else begin
          ctrl.rf_outa_sel = rd;
          ctrl.mux_c_sel   = 1'b0;
          ctrl.alu_funsel  = ALU_PASSA;
          ctrl.mem_wr      = 1'b1;
        end
      end
      S_HALT: ctrl.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: state register, zero-flag register and next-state
// logic; the control outputs come from ctrl_decode. No handshakes: every
// state lasts exactly one cycle and T exposes the current state for debug.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] IRout,
  input  logic [3:0]  Flags,
  output logic [1:0]  RF_OutASel,
  output logic [1:0]  RF_OutBSel,
  output logic [1:0]  RF_FunSel,
  output logic [3:0]  RF_RegSel,
  output logic [1:0]  ARF_OutCSel,
  output logic [1:0]  ARF_OutDSel,
  output logic [1:0]  ARF_FunSel,
  output logic [3:0]  ARF_RegSel,
  output logic        IR_LH,
  output logic        IR_En,
  output logic [1:0]  IR_FunSel,
  output logic [3:0]  ALU_FunSel,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic        MuxCSel,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic        Halted,
  output logic [2:0]  T
);

  state_e     state_q, state_d;
  logic       zreg_q, zreg_d;
  ctrl_t      ctrl;
  logic [3:0] op;

  assign op = IRout[15:12];

  // Only Z is consumed; low immediate bits go straight to the datapath
  logic unused_bits;
  assign unused_bits = ^{Flags[3:1], IRout[5:0]};

  // Next state and zero-flag capture for ALU ops
  always_comb begin
    state_d = state_q;
    zreg_d  = zreg_q;
    case (state_q)
      S_CLR:  state_d = S_F0;
      S_F0:   state_d = S_F1;
      S_F1:   state_d = S_EX;
      S_EX: begin
        if (op[3] == 1'b0) zreg_d = Flags[0];
        if (op == OP_LD || op == OP_ST) state_d = S_MEM;
        else if (op == OP_HLT)          state_d = S_HALT;
        else                            state_d = S_F0;
      end
      S_MEM:  state_d = S_F0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_CLR;
    endcase
  end

  // State and zreg registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_CLR;
      zreg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      zreg_q  <= zreg_d;
    end
  end

  ctrl_decode #(.RESET_PC(RESET_PC)) u_decode (
    .state (state_q),
    .op    (op),
    .rd    (IRout[11:10]),
    .rs1   (IRout[9:8]),
    .rs2   (IRout[7:6]),
    .zreg  (zreg_q),
    .ctrl  (ctrl)
  );

  assign RF_OutASel  = ctrl.rf_outa_sel;
  assign RF_OutBSel  = ctrl.rf_outb_sel;
  assign RF_FunSel   = ctrl.rf_funsel;
  assign RF_RegSel   = ctrl.rf_regsel;
  assign ARF_OutCSel = ctrl.arf_outc_sel;
  assign ARF_OutDSel = ctrl.arf_outd_sel;
  assign ARF_FunSel  = ctrl.arf_funsel;
  assign ARF_RegSel  = ctrl.arf_regsel;
  assign IR_LH       = ctrl.ir_lh;
  assign IR_En       = ctrl.ir_en;
  assign IR_FunSel   = ctrl.ir_funsel;
  assign ALU_FunSel  = ctrl.alu_funsel;
  assign MuxASel     = ctrl.mux_a_sel;
  assign MuxBSel     = ctrl.mux_b_sel;
  assign MuxCSel     = ctrl.mux_c_sel;
  assign Mem_WR      = ctrl.mem_wr;
  assign Mem_CS      = ctrl.mem_cs;
  assign Halted      = ctrl.halted;
  assign T           = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks reset, fetch, every execute
// class, memory ops, halt and reset-interrupts with hand-computed outputs.
module tb_control_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] IRout = 16'h0000;
  logic [3:0]  Flags = 4'h0;
  logic [1:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
  logic [3:0]  RF_RegSel;
  logic [1:0]  ARF_OutCSel, ARF_OutDSel, ARF_FunSel;
  logic [3:0]  ARF_RegSel;
  logic        IR_LH, IR_En;
  logic [1:0]  IR_FunSel;
  logic [3:0]  ALU_FunSel;
  logic [1:0]  MuxASel, MuxBSel;
  logic        MuxCSel, Mem_WR, Mem_CS, Halted;
  logic [2:0]  T;

  int n_vec  = 0;
  int n_miss = 0;
  logic [3:0] exp_alu [8];

  control_sequencer dut (
    .CLK(CLK), .RST(RST), .IRout(IRout), .Flags(Flags),
    .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
    .RF_RegSel(RF_RegSel), .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel),
    .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel), .IR_LH(IR_LH), .IR_En(IR_En),
    .IR_FunSel(IR_FunSel), .ALU_FunSel(ALU_FunSel), .MuxASel(MuxASel),
    .MuxBSel(MuxBSel), .MuxCSel(MuxCSel), .Mem_WR(Mem_WR), .Mem_CS(Mem_CS),
    .Halted(Halted), .T(T)
  );

  // Clock
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled at the following falling edge
  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // From S_F0: check both fetch cycles, present ir, land in S_EX
  task automatic fetch(input logic [15:0] ir);
    check("f0_T", 16'(T), 16'd1);
    check("f0_dsel", 16'(ARF_OutDSel), 16'h1);
    check("f0_ir", {12'h0, Mem_CS, IR_En, IR_LH, 1'b0}, 16'h0004);
    step();
    check("f1_T", 16'(T), 16'd2);
    check("f1_ir", {12'h0, Mem_CS, IR_En, IR_LH, 1'b0}, 16'h0006);
    check("f1_pcinc", {8'h0, ARF_RegSel, 2'b00, ARF_FunSel}, 16'h00E1);
    IRout = ir;
    step();
    check("ex_T", 16'(T), 16'd3);
  endtask

  initial begin
    exp_alu = '{4'b0111, 4'b1000, 4'b1001, 4'b0100, 4'b0110, 4'b0010, 4'b1010, 4'b1011};

    // Reset held two cycles -> S_CLR
    @(negedge CLK);
    step();
    step();
    check("clr_T", 16'(T), 16'd0);
    check("clr_rf", {8'h0, RF_RegSel, 2'b00, RF_FunSel}, 16'h0003);
    check("clr_arf", {8'h0, ARF_RegSel, 2'b00, ARF_FunSel}, 16'h0083);
    check("clr_idle", {12'h0, Mem_CS, Mem_WR, IR_En, Halted}, 16'h0008);
    RST = 1'b0;
    step();
    check("f0_irfun", 16'(IR_FunSel), 16'h2);

    // LDI R2,5 (Rd=01)
    fetch(16'hA405);
    check("ldi_regsel", 16'(RF_RegSel), 16'hD);
    check("ldi_mux", {12'h0, MuxASel, RF_FunSel}, 16'h000A);
    step();

    // ADD Rd=11 Rs1=10 Rs2=01, Z=1 -> zreg=1
    fetch(16'h3E40);
    check("add_alu", 16'(ALU_FunSel), 16'h4);
    check("add_regsel", 16'(RF_RegSel), 16'h7);
    check("add_sel", {8'h0, RF_OutASel, RF_OutBSel, MuxASel, 1'b0, MuxCSel}, 16'h0090);
    Flags = 4'b0001;
    step();
    Flags = 4'b0000;

    // BNE with zreg=1: no PC write
    fetch(16'hE020);
    check("bne_taken_no", {8'h0, ARF_RegSel, 2'b00, MuxBSel}, 16'h00F0);
    step();

    // SUB Rd=00 with Z=0 -> zreg=0
    fetch(16'h4000);
    check("sub_alu", 16'(ALU_FunSel), 16'h6);
    check("sub_regsel", 16'(RF_RegSel), 16'hE);
    step();

    // INC Rd=10 with Z=1 on the bus: zreg must stay 0
    fetch(16'h8800);
    check("inc_rf", {8'h0, RF_RegSel, 2'b00, RF_FunSel}, 16'h00B1);
    Flags = 4'b0001;
    step();
    Flags = 4'b0000;

    // BNE with zreg=0: PC <= IR[7:0]
    fetch(16'hE020);
    check("bne_arf", {8'h0, ARF_RegSel, 2'b00, ARF_FunSel}, 16'h00E2);
    check("bne_muxb", 16'(MuxBSel), 16'h2);
    step();

    // DEC Rd=11
    fetch(16'h9C00);
    check("dec_rf", {8'h0, RF_RegSel, 2'b00, RF_FunSel}, 16'h0070);
    step();

    // BRA unconditional
    fetch(16'hD010);
    check("bra_arf", {8'h0, ARF_RegSel, MuxBSel, ARF_FunSel}, 16'h00EA);
    step();

    // All register-register ALU ops, Rd == Rs1 == 10, Rs2 == 01
    for (int i = 0; i < 8; i++) begin
      fetch({i[3:0], 2'b10, 2'b10, 2'b01, 6'b000000});
      check("alu_op", 16'(ALU_FunSel), 16'(exp_alu[i]));
      check("alu_regsel", 16'(RF_RegSel), 16'hB);
      check("alu_ab", {12'h0, RF_OutASel, RF_OutBSel}, 16'h0009);
      step();
    end

    // ST R2 (Rd=01), 0x80
    fetch(16'hC480);
    check("st_ex", {8'h0, ARF_RegSel, MuxBSel, ARF_FunSel}, 16'h00DA);
    step();
    check("st_T", 16'(T), 16'd4);
    check("st_mem", {12'h0, Mem_CS, Mem_WR, ARF_OutDSel}, 16'h0006);
    check("st_outa", {8'h0, ALU_FunSel, RF_OutASel, 1'b0, MuxCSel}, 16'h0004);
    check("st_norf", 16'(RF_RegSel), 16'hF);
    step();

    // LD Rd=10, reset asserted while in S_MEM
    fetch(16'hB880);
    step();
    check("ld_rf", {8'h0, RF_RegSel, MuxASel, RF_FunSel}, 16'h00B6);
    check("ld_mem", {12'h0, Mem_CS, Mem_WR, ARF_OutDSel}, 16'h0002);
    RST = 1'b1;
    step();
    check("rst_mem_T", 16'(T), 16'd0);
    RST = 1'b0;
    step();

    // HLT: stays halted with idle outputs until reset
    fetch(16'hF000);
    check("hlt_ex_idle", {8'h0, RF_RegSel, ARF_RegSel}, 16'h00FF);
    step();
    for (int i = 0; i < 10; i++) begin
      check("halt_state", {12'h0, T, Halted}, 16'h000B);
      check("halt_idle", {12'h0, Mem_CS, IR_En, Mem_WR, 1'b0}, 16'h0008);
      step();
    end
    RST = 1'b1;
    step();
    check("rst_halt", {12'h0, T, Halted}, 16'h0000);
    RST = 1'b0;
    step();
    check("restart_T", 16'(T), 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
